inst_fetch: RTL

Instruction fetch stage that sits directly upstream of the decoder. It owns the fetch PC and issues in-order read requests to instruction memory. Returned words go into a small prefetch FIFO, and each {pc, inst} pair is handed to decode over a valid/ready handshake. Redirects from branch/jump resolution flush the FIFO and discard any responses still in flight, so decode only ever sees instructions on the new path.

---
 rtl/inst_fetch.sv | 111 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem reads under a
// credit limit, buffers returned words in a prefetch FIFO and hands {pc, inst} to decode.
//
// Handshakes: a transfer happens on a cycle where valid & ready (req & gnt on the
// memory side, out_valid & out_ready toward decode); valid never waits on ready.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW-1:0] rp_wptr_q, rp_rptr_q;
    logic [CW-1:0] count_q, count_d, pend_q, pend_d, drop_q, drop_d;
    logic          alive_q;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   resp_pc_q   [DEPTH];

    logic [CW:0]   credit;
    logic          grant, push, pop;

    // Buffered entries plus in-flight requests never exceed DEPTH, so no response can overflow the FIFO.
    assign credit    = {1'b0, count_q} + {1'b0, pend_q};
    assign imem_req  = alive_q & ~redirect_valid & (credit < (CW + 1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req & imem_gnt;

    assign push      = imem_rvalid & ~redirect_valid & (drop_q == '0);
    assign out_valid = (count_q != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign out_inst  = fifo_inst_q[rptr_q];
    assign out_pc    = fifo_pc_q[rptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        pend_d     = pend_q + CW'(grant) - CW'(imem_rvalid);
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            // Every request still outstanding after this cycle belongs to the old path.
            drop_d     = pend_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rp_wptr_q  <= '0;
            rp_rptr_q  <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            alive_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
                resp_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            alive_q    <= 1'b1;
            if (push) begin
                fifo_pc_q[wptr_q]   <= resp_pc_q[rp_rptr_q];
                fifo_inst_q[wptr_q] <= imem_rdata;
            end
            if (grant) begin
                resp_pc_q[rp_wptr_q] <= fetch_pc_q;
                rp_wptr_q            <= rp_wptr_q + AW'(1);
            end
            if (imem_rvalid) rp_rptr_q <= rp_rptr_q + AW'(1);
        end
    end

endmodule
